// File: rtl/cam_pixel_packer.sv
// Camera-side pixel assembler: gathers sensor bytes into RGB565 words for the frame buffer vin port,
// with byte-order selection, RAW8 expansion, crop window, 2:1 decimation and odd-line detection.
module cam_pixel_packer #(
    parameter int   DIN_W  = 10,
    parameter int   CNT_W  = 12,
    parameter logic VS_POL = 1'b1
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_vsync,
    input  logic             I_href,
    input  logic [DIN_W-1:0] I_data,
    input  logic [1:0]       I_mode,
    input  logic             I_dec,
    input  logic [CNT_W-1:0] I_crop_x,
    input  logic [CNT_W-1:0] I_crop_y,
    input  logic [CNT_W-1:0] I_crop_w,
    input  logic [CNT_W-1:0] I_crop_h,
    output logic             O_vs_n,
    output logic             O_de,
    output logic [15:0]      O_data,
    output logic             O_line_err,
    output logic             O_err_sticky,
    output logic [CNT_W-1:0] O_lines
);
    localparam logic [1:0]       MODE_LSB  = 2'd1;
    localparam logic [1:0]       MODE_RAW8 = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             vs_act_s, vs_prev_r, href_prev_r;
    logic             frame_start_s, href_fall_s;
    logic [1:0]       mode_r;
    logic             dec_r;
    logic [CNT_W-1:0] crop_x_r, crop_y_r, crop_w_r, crop_h_r;
    logic             phase_r;
    logic [7:0]       byte_s, byte0_r;
    logic [CNT_W-1:0] x_r, y_r;
    logic             x_over_r, y_over_r;
    logic             byte_en_s, wide_s, pix_done_s, odd_s;
    logic             x_in_s, y_in_s, dec_ok_s, keep_s;
    logic [CNT_W:0]   x_end_s, y_end_s;
    logic [15:0]      pix_s;
    logic             data_unused_s;

    assign byte_s        = I_data[DIN_W-1 -: 8];
    assign data_unused_s = ^I_data;
    assign vs_act_s      = (I_vsync == VS_POL);
    assign frame_start_s = vs_act_s && !vs_prev_r;
    assign href_fall_s   = href_prev_r && !I_href;
    assign byte_en_s     = I_href && !vs_act_s;
    assign wide_s        = (mode_r != MODE_RAW8);
    assign pix_done_s    = byte_en_s && (!wide_s || phase_r);
    assign odd_s         = href_fall_s && phase_r && wide_s;

    // Window ends use one extra bit so crop_x+crop_w cannot wrap; x/y_over mark positions past saturation
    assign x_end_s  = {1'b0, crop_x_r} + {1'b0, crop_w_r};
    assign y_end_s  = {1'b0, crop_y_r} + {1'b0, crop_h_r};
    assign x_in_s   = (x_r >= crop_x_r) &&
                      ((crop_w_r == CNT_ZERO) || (!x_over_r && ({1'b0, x_r} < x_end_s)));
    assign y_in_s   = (y_r >= crop_y_r) &&
                      ((crop_h_r == CNT_ZERO) || (!y_over_r && ({1'b0, y_r} < y_end_s)));
    assign dec_ok_s = !dec_r || (!x_r[0] && !y_r[0]);
    assign keep_s   = x_in_s && y_in_s && dec_ok_s;

    // Pixel word for the byte completing this cycle
    always_comb begin
        pix_s = {byte0_r, byte_s};
        case (mode_r)
            MODE_LSB:  pix_s = {byte_s, byte0_r};
            MODE_RAW8: pix_s = {byte_s[7:3], byte_s[7:2], byte_s[7:3]};
            default:   pix_s = {byte0_r, byte_s};
        endcase
    end

    // Sync edge tracking, per-frame configuration latch and previous-frame line count
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            vs_prev_r   <= 1'b0;
            href_prev_r <= 1'b0;
            mode_r      <= 2'd0;
            dec_r       <= 1'b0;
            crop_x_r    <= CNT_ZERO;
            crop_y_r    <= CNT_ZERO;
            crop_w_r    <= CNT_ZERO;
            crop_h_r    <= CNT_ZERO;
            O_lines     <= CNT_ZERO;
        end else begin
            vs_prev_r   <= vs_act_s;
            href_prev_r <= I_href;
            if (frame_start_s) begin
                mode_r   <= I_mode;
                dec_r    <= I_dec;
                crop_x_r <= I_crop_x;
                crop_y_r <= I_crop_y;
                crop_w_r <= I_crop_w;
                crop_h_r <= I_crop_h;
                O_lines  <= y_r;
            end
        end
    end

    // Byte phase, held first byte and saturating pixel column counter
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            phase_r  <= 1'b0;
            byte0_r  <= 8'h00;
            x_r      <= CNT_ZERO;
            x_over_r <= 1'b0;
        end else if (!I_href) begin
            phase_r  <= 1'b0;
            x_r      <= CNT_ZERO;
            x_over_r <= 1'b0;
        end else if (byte_en_s) begin
            phase_r <= wide_s && !phase_r;
            if (wide_s && !phase_r) begin
                byte0_r <= byte_s;
            end
            if (pix_done_s) begin
                if (x_r == CNT_MAX) begin
                    x_over_r <= 1'b1;
                end else begin
                    x_r <= x_r + CNT_ONE;
                end
            end
        end else begin
            phase_r <= 1'b0;
        end
    end

    // Saturating line counter; frame start wins over a coincident href fall
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            y_r      <= CNT_ZERO;
            y_over_r <= 1'b0;
        end else if (frame_start_s) begin
            y_r      <= CNT_ZERO;
            y_over_r <= 1'b0;
        end else if (href_fall_s) begin
            if (y_r == CNT_MAX) begin
                y_over_r <= 1'b1;
            end else begin
                y_r <= y_r + CNT_ONE;
            end
        end
    end

    // Registered outputs, all with one cycle of latency so sync and data stay aligned
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            O_vs_n       <= 1'b1;
            O_de         <= 1'b0;
            O_data       <= 16'h0000;
            O_line_err   <= 1'b0;
            O_err_sticky <= 1'b0;
        end else begin
            O_vs_n     <= !vs_act_s;
            O_de       <= pix_done_s && keep_s;
            O_line_err <= odd_s;
            if (pix_done_s && keep_s) begin
                O_data <= pix_s;
            end
            if (odd_s) begin
                O_err_sticky <= 1'b1;
            end else if (frame_start_s) begin
                O_err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer: expected pixels and arrival cycles queued at drive time,
// matched against every O_de strobe by a monitor on the falling edge.
module tb_cam_pixel_packer;
    localparam int DIN_W = 10;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n, vsync, href, dec;
    logic [DIN_W-1:0] data;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cx, cy, cw, ch;
    logic             vs_n, de, line_err, err_sticky;
    logic [15:0]      odata;
    logic [CNT_W-1:0] lines;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_de = 0;
    int   n_lerr = 0;
    int   de_base;

    cam_pixel_packer #(.DIN_W(DIN_W), .CNT_W(CNT_W), .VS_POL(1'b1)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_vsync(vsync), .I_href(href), .I_data(data),
        .I_mode(mode), .I_dec(dec), .I_crop_x(cx), .I_crop_y(cy), .I_crop_w(cw), .I_crop_h(ch),
        .O_vs_n(vs_n), .O_de(de), .O_data(odata), .O_line_err(line_err),
        .O_err_sticky(err_sticky), .O_lines(lines)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to check output latency
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every strobe must match the oldest queued pixel, at the queued cycle
    always @(negedge clk) begin
        exp_t e;
        if (line_err === 1'b1) n_lerr++;
        if (de === 1'b1) begin
            n_de++;
            n_chk++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL stray_de observed data=%h expected no strobe", odata);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                assert (odata === e.data) else begin
                    n_fail++;
                    $error("FAIL pixel_data observed=%h expected=%h", odata, e.data);
                end
                n_chk++;
                assert (cyc === e.cyc) else begin
                    n_fail++;
                    $error("FAIL pixel_latency observed cycle=%0d expected cycle=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic [7:0] b);
        href = h;
        data = {b, 2'b00};
        tick();
    endtask

    task automatic push(input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic gap(input int n);
        href = 1'b0;
        repeat (n) tick();
    endtask

    task automatic frame_start();
        href  = 1'b0;
        vsync = 1'b1;
        tick();
        check("vs_n_active", {31'd0, vs_n}, 32'd0);
        tick();
        vsync = 1'b0;
        tick();
        check("vs_n_idle", {31'd0, vs_n}, 32'd1);
        gap(2);
    endtask

    task automatic drain(input string tag);
        gap(3);
        check(tag, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        logic [7:0] hb, lb;
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; data = '0; mode = 2'd0; dec = 1'b0;
        cx = '0; cy = '0; cw = '0; ch = '0;
        tick(); tick();
        check("rst_vs_n", {31'd0, vs_n}, 32'd1);
        check("rst_de", {31'd0, de}, 32'd0);
        check("rst_data", {16'd0, odata}, 32'd0);
        check("rst_line_err", {31'd0, line_err}, 32'd0);
        check("rst_sticky", {31'd0, err_sticky}, 32'd0);
        check("rst_lines", {20'd0, lines}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Mode 0: high byte first
        mode = 2'd0;
        frame_start();
        drive(1'b1, 8'hF8); push(16'hF800); drive(1'b1, 8'h00);
        drive(1'b1, 8'h07); push(16'h07E0); drive(1'b1, 8'hE0);
        drive(1'b1, 8'h00); push(16'h001F); drive(1'b1, 8'h1F);
        drive(1'b1, 8'hFF); push(16'hFFFF); drive(1'b1, 8'hFF);
        drain("mode0_missing");

        // Mode 1: low byte first
        mode = 2'd1;
        frame_start();
        drive(1'b1, 8'hF8); push(16'h00F8); drive(1'b1, 8'h00);
        drive(1'b1, 8'h07); push(16'hE007); drive(1'b1, 8'hE0);
        drive(1'b1, 8'h00); push(16'h1F00); drive(1'b1, 8'h1F);
        drive(1'b1, 8'hFF); push(16'hFFFF); drive(1'b1, 8'hFF);
        drain("mode1_missing");

        // Mode 2: RAW8 grey, every byte is a pixel, odd byte count is legal
        mode = 2'd2;
        frame_start();
        for (int i = 0; i < 5; i++) begin
            push(16'h8410);
            drive(1'b1, 8'h80);
        end
        drain("mode2_missing");

        // Crop window on a 6x4 frame
        mode = 2'd0; cx = 12'd2; cy = 12'd1; cw = 12'd3; ch = 12'd2;
        frame_start();
        de_base = n_de;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 6; x++) begin
                hb = 8'h10 + 8'(y);
                lb = 8'h20 + 8'(x);
                drive(1'b1, hb);
                if (x >= 2 && x < 5 && y >= 1 && y < 3) push({hb, lb});
                drive(1'b1, lb);
            end
            gap(3);
        end
        drain("crop_missing");
        check("crop_count", n_de - de_base, 32'd6);

        // Decimation on an 8x4 frame
        cx = '0; cy = '0; cw = '0; ch = '0; dec = 1'b1;
        frame_start();
        check("lines_crop_frame", {20'd0, lines}, 32'd4);
        de_base = n_de;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                hb = 8'h40 + 8'(y);
                lb = 8'h50 + 8'(x);
                drive(1'b1, hb);
                if (x % 2 == 0 && y % 2 == 0) push({hb, lb});
                drive(1'b1, lb);
            end
            gap(3);
        end
        drain("dec_missing");
        check("dec_count", n_de - de_base, 32'd8);

        // Odd byte count in a 16-bit mode
        dec = 1'b0;
        frame_start();
        check("lines_dec_frame", {20'd0, lines}, 32'd4);
        check("lerr_none_yet", n_lerr, 32'd0);
        drive(1'b1, 8'h11); push(16'h1122); drive(1'b1, 8'h22);
        drive(1'b1, 8'h33); push(16'h3344); drive(1'b1, 8'h44);
        drive(1'b1, 8'h55);
        href = 1'b0;
        tick();
        check("line_err_pulse", {31'd0, line_err}, 32'd1);
        check("sticky_set", {31'd0, err_sticky}, 32'd1);
        tick();
        check("line_err_single", {31'd0, line_err}, 32'd0);
        gap(2);
        drive(1'b1, 8'h66); push(16'h6677); drive(1'b1, 8'h77);
        drain("odd_missing");
        check("sticky_held", {31'd0, err_sticky}, 32'd1);
        frame_start();
        check("sticky_cleared", {31'd0, err_sticky}, 32'd0);
        check("lerr_count", n_lerr, 32'd1);

        // Reset after the first byte of a pair
        drive(1'b1, 8'hAB);
        gap(3);
        check("sticky_again", {31'd0, err_sticky}, 32'd1);
        drive(1'b1, 8'hAA);
        rst_n = 1'b0;
        href  = 1'b1;
        data  = {8'hBB, 2'b00};
        tick();
        check("mid_rst_data", {16'd0, odata}, 32'd0);
        check("mid_rst_de", {31'd0, de}, 32'd0);
        check("mid_rst_sticky", {31'd0, err_sticky}, 32'd0);
        check("mid_rst_lines", {20'd0, lines}, 32'd0);
        check("mid_rst_vs_n", {31'd0, vs_n}, 32'd1);
        rst_n = 1'b1;
        de_base = n_de;
        drive(1'b1, 8'h12); push(16'h1234); drive(1'b1, 8'h34);
        drain("post_rst_missing");
        check("post_rst_count", n_de - de_base, 32'd1);
        check("lerr_total", n_lerr, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
